// File: rtl/riscv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_fetch_pkg
// Brief    : Shared types and constants for the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] ILLEGAL_ZERO = 32'h0000_0000;
    localparam logic [XLEN-1:0]        PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [XLEN-1:0]        pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Brief    : 2-entry FIFO of {instr, pc}; flush beats push, pop allowed with flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import riscv_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam logic [1:0] DEPTH = 2'd2;

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign do_pop  = pop & (count_q != 2'd0);
    assign do_push = push & ~flush & ((count_q != DEPTH) | do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == DEPTH);
    assign empty = (count_q == 2'd0);

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Fetch stage: PC, imem interface, 2-entry output buffer, redirect/halt.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   fetch_en,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_pc_plus4,
    output logic                   halted,
    output logic                   fault,
    output logic [31:0]            fetch_count
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     fetch_count_q, fetch_count_d;

    logic            buf_push, buf_pop, buf_flush, buf_full, buf_empty;
    fetch_entry_t    buf_head;
    fetch_entry_t    buf_wdata;

    assign buf_pop   = out_valid & out_ready;
    assign buf_wdata = '{instr: imem_rdata, pc: pc_q};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        buf_push      = 1'b0;
        buf_flush     = 1'b0;
        if (redirect_valid) begin
            // Redirect wins in every state; a misaligned target parks the stage in FAULT.
            buf_flush = 1'b1;
            if (redirect_pc[1:0] == 2'b00) begin
                pc_d    = redirect_pc;
                state_d = ST_RUN;
            end else begin
                state_d = ST_FAULT;
            end
        end else if ((state_q == ST_RUN) && fetch_en && (!buf_full || buf_pop)) begin
            if (imem_rdata != ILLEGAL_ZERO) begin
                buf_push      = 1'b1;
                pc_d          = pc_q + PC_STEP;
                fetch_count_d = fetch_count_q + 32'd1;
            end else begin
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (buf_push),
        .pop       (buf_pop),
        .flush     (buf_flush),
        .push_data (buf_wdata),
        .full      (buf_full),
        .empty     (buf_empty),
        .head      (buf_head)
    );

    assign imem_addr    = pc_q;
    assign out_valid    = ~buf_empty;
    assign out_instr    = buf_head.instr;
    assign out_pc       = buf_head.pc;
    assign out_pc_plus4 = buf_head.pc + PC_STEP;
    assign halted       = (state_q == ST_HALT);
    assign fault        = (state_q == ST_FAULT);
    assign fetch_count  = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed + random bench for instr_fetch against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .halted         (halted),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    // Instruction memory: 64 words at 0x00..0xFC plus one word at the top of the address space.
    logic [31:0] mem [0:63];
    logic [31:0] hi_word;

    assign imem_rdata = (imem_addr == 32'hFFFF_FFFC) ? hi_word :
                        (imem_addr[31:8] == 24'h0)   ? mem[imem_addr[7:2]] : 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hFFFF_FFFC) return hi_word;
        if (a[31:8] == 24'h0)   return mem[a[7:2]];
        return 32'h0;
    endfunction

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer is a plain queue, mode 0=run 1=halt 2=fault.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc   = 32'h0;
    logic [31:0] m_cnt  = 32'h0;
    int          m_mode = 0;

    task automatic model_reset();
        mq.delete();
        m_pc   = 32'h0;
        m_cnt  = 32'h0;
        m_mode = 0;
    endtask

    task automatic model_step();
        bit          pop;
        bit          room;
        logic [31:0] w;
        pop  = out_ready && (mq.size() > 0);
        room = (mq.size() < 2) || pop;
        if (pop) void'(mq.pop_front());
        if (redirect_valid) begin
            mq.delete();
            if (redirect_pc[1:0] == 2'b00) begin
                m_pc   = redirect_pc;
                m_mode = 0;
            end else begin
                m_mode = 2;
            end
        end else if (m_mode == 0 && fetch_en && room) begin
            w = mem_word(m_pc);
            if (w != 32'h0) begin
                mq.push_back('{instr: w, pc: m_pc});
                m_pc  = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end else begin
                m_mode = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) model_reset();
        else          model_step();
    end

    // Compare process and handshake log, sampled 2 time units before each rising edge.
    bit          chk_en = 1'b0;
    logic [31:0] log_pc[$];
    logic [31:0] log_p4[$];
    logic [31:0] log_in[$];

    initial forever begin
        @(negedge clk);
        #3;
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("out_instr", out_instr, mq[0].instr);
                chk("out_pc", out_pc, mq[0].pc);
                chk("out_pc_plus4", out_pc_plus4, mq[0].pc + 32'd4);
            end
            chk("imem_addr", imem_addr, m_pc);
            chk("halted", 32'(halted), 32'(m_mode == 1));
            chk("fault", 32'(fault), 32'(m_mode == 2));
            chk("fetch_count", fetch_count, m_cnt);
        end
        if (reset_n && out_valid && out_ready) begin
            log_pc.push_back(out_pc);
            log_p4.push_back(out_pc_plus4);
            log_in.push_back(out_instr);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic clear_log();
        log_pc.delete();
        log_p4.delete();
        log_in.delete();
    endtask

    initial begin
        int unsigned t;
        int unsigned r;
        fetch_en       = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        hi_word        = 32'h0;
        for (int k = 0; k < 64; k++) mem[k] = 32'h0;
        mem[0] = 32'h0010_0093;
        mem[1] = 32'h0010_0113;
        mem[2] = 32'h0020_a1b3;
        mem[3] = 32'h0000_0000;

        // Straight run to the terminator with a always-ready consumer.
        out_ready = 1'b1;
        do_reset();
        chk_en = 1'b1;
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_pc_plus4", out_pc_plus4, 32'h4);
        clear_log();
        for (int i = 0; i < 8; i++) tick();
        chk("run handshakes", 32'(log_pc.size()), 32'd3);
        if (log_pc.size() == 3) begin
            chk("run pc0", log_pc[0], 32'h0);
            chk("run pc1", log_pc[1], 32'h4);
            chk("run pc2", log_pc[2], 32'h8);
            chk("run p4_0", log_p4[0], 32'h4);
            chk("run p4_2", log_p4[2], 32'hC);
            chk("run instr0", log_in[0], 32'h0010_0093);
        end
        chk("run halted", 32'(halted), 32'h1);
        chk("run fetch_count", fetch_count, 32'd3);

        // Back-pressure: buffer fills at two entries and holds.
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        chk("bp out_valid", 32'(out_valid), 32'h1);
        chk("bp out_pc", out_pc, 32'h0);
        chk("bp out_instr", out_instr, 32'h0010_0093);
        chk("bp imem_addr", imem_addr, 32'h8);
        chk("bp fetch_count", fetch_count, 32'd2);
        clear_log();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("bp drained", 32'(log_pc.size()), 32'd3);
        if (log_pc.size() == 3) begin
            chk("bp order0", log_pc[0], 32'h0);
            chk("bp order1", log_pc[1], 32'h4);
            chk("bp order2", log_pc[2], 32'h8);
        end

        // Redirect coinciding with a pop of pc 0.
        out_ready = 1'b0;
        do_reset();
        tick();
        tick();
        clear_log();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4;
        tick();
        redirect_valid = 1'b0;
        chk("redir bubble", 32'(out_valid), 32'h0);
        chk("redir imem_addr", imem_addr, 32'h4);
        tick();
        chk("redir valid", 32'(out_valid), 32'h1);
        chk("redir pc", out_pc, 32'h4);
        chk("redir instr", out_instr, 32'h0010_0113);
        chk("redir popped", 32'(log_pc.size()), 32'd1);
        if (log_pc.size() == 1) chk("redir popped pc", log_pc[0], 32'h0);

        // Misaligned redirect, then recovery.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        tick();
        redirect_valid = 1'b0;
        chk("fault set", 32'(fault), 32'h1);
        chk("fault out_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 3; i++) tick();
        chk("fault held", 32'(fault), 32'h1);
        chk("fault no fetch", 32'(out_valid), 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        chk("fault clear", 32'(fault), 32'h0);
        chk("resume addr", imem_addr, 32'h0);
        tick();
        chk("resume valid", 32'(out_valid), 32'h1);
        chk("resume pc", out_pc, 32'h0);

        // Asynchronous reset mid-cycle with a full buffer.
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset out_valid", 32'(out_valid), 32'h0);
        chk("areset halted", 32'(halted), 32'h0);
        chk("areset fault", 32'(fault), 32'h0);
        chk("areset fetch_count", fetch_count, 32'h0);
        chk("areset imem_addr", imem_addr, 32'h0);
        chk("areset out_instr", out_instr, 32'h0);
        chk("areset out_pc_plus4", out_pc_plus4, 32'h4);
        tick();
        reset_n = 1'b1;

        // PC wrap at the top of the address space.
        out_ready      = 1'b1;
        hi_word        = 32'h0000_0013;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap valid", 32'(out_valid), 32'h1);
        chk("wrap pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap pc_plus4", out_pc_plus4, 32'h0);
        chk("wrap instr", out_instr, 32'h0000_0013);
        chk("wrap next addr", imem_addr, 32'h0);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 4; k < 64; k++)
            mem[k] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
        hi_word = $urandom | 32'h1;
        for (int i = 0; i < 3000; i++) begin
            fetch_en       = ($urandom_range(0, 99) < 85);
            out_ready      = ($urandom_range(0, 99) < 60);
            redirect_valid = ($urandom_range(0, 99) < 6);
            t = $urandom_range(0, 255);
            r = $urandom_range(0, 7);
            if (r == 0)      redirect_pc = 32'hFFFF_FFFC;
            else if (r <= 2) redirect_pc = t;
            else             redirect_pc = t & 32'hFFFF_FFFC;
            tick();
        end
        redirect_valid = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the multi-cycle RISC-V CPU, sitting between the program counter logic and the control/decode stage. Drives the byte address into the combinational instruction memory and captures the returned word with its PC into a 2-entry buffer. Presents {instr, pc, pc+4} to the control FSM over a valid/ready handshake. Supports redirects for branches and jumps, and halts on the all-zero terminator word.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded at reset; must be word-aligned.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  global run enable; 0 freezes fetching but not the handshake or redirects.
- imem_addr  out  32  byte address to instruction memory; equals the registered PC.
- imem_rdata  in  32  instruction word, combinational from imem_addr, same cycle.
- redirect_valid  in  1  load new PC (branch/jump target); one-cycle pulse.
- redirect_pc  in  32  target byte address.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  consumer accepts head.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- out_pc_plus4  out  32  out_pc + 4, mod 2^32.
- halted  out  1  zero word fetched; fetch stopped.
- fault  out  1  misaligned redirect target; fetch stopped.
- fetch_count  out  32  number of words pushed since reset; wraps.

## Operation
- FSM states: RUN, HALT, FAULT. Reset state is RUN.
- RUN, push condition: fetch_en=1, no redirect this cycle, and buffer has room. Room means count<2, or count==2 with a pop this cycle.
  - If imem_rdata != 0: push {imem_rdata, pc}, pc <= pc+4 (wraps at 2^32), fetch_count+1.
  - If imem_rdata == 0: no push, pc unchanged, go to HALT.
- HALT: no fetch. halted=1. Buffered entries still drain normally.
- FAULT: no fetch. fault=1. Buffer was flushed on entry.
- Redirect (any state) has highest priority:
  - A handshake completing in the same cycle still counts as consumed.
  - Buffer is then flushed; no push that cycle.
  - If redirect_pc[1:0]==0: pc <= redirect_pc, go to RUN, halted and fault clear.
  - Otherwise: pc unchanged, go to FAULT.
- Pop: out_valid & out_ready. Head advances; push and pop in the same cycle are legal at any occupancy.
- out_* reflect the buffer head only. They hold stable while out_valid=1 and out_ready=0.
- Reset values: pc=RESET_PC, buffer empty, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=4, halted=0, fault=0, fetch_count=0.
- Reset mid-operation clears everything asynchronously. Buffered entries are discarded.

## Timing
- imem_addr is combinational from pc, so it changes only after a clock edge.
- Fetch latency: word captured at edge N is at the head with out_valid=1 after edge N (cycle N+1) if the buffer was empty.
- Steady state with out_ready=1 and fetch_en=1: one instruction per cycle.
- Redirect at edge N: out_valid=0 during cycle N+1; first target instruction valid in cycle N+2.
- HALT/FAULT entry: halted/fault asserted in the cycle after the triggering edge.
- out_ready may depend combinationally on out_valid. out_valid must not depend on out_ready.
- fetch_en deassert takes effect at the next edge; no partial fetches exist.

## Structure
- Shared package riscv_fetch_pkg contains:
  - fetch state encoding (RUN/HALT/FAULT);
  - INSTR_WIDTH=32 and XLEN=32;
  - ILLEGAL_ZERO=32'h0;
  - PC_STEP=4;
  - the buffer entry layout {instr[31:0], pc[31:0]}.
- Sub-module fetch_buffer: 2-entry FIFO with push, pop, flush, full, empty and head outputs.
  - Flush has priority over push. Pop of the current head is allowed in the flush cycle.

## Test plan
- Reset, then run the program 0x00100093, 0x00100113, 0x0020a1b3, 0x00000000 with out_ready=1.
  - Required: three handshakes with pc 0, 4, 8; out_pc_plus4 4, 8, 12.
  - Required: halted=1 after pc=12 is sampled; fetch_count=3.
- Same program with out_ready=0 for 5 cycles.
  - Required: buffer fills at 2 entries (pc 0, 4); imem_addr holds 8; out_* stable.
  - Required: on release, remaining entries drain in order with no loss or duplicates.
- Redirect to 0x4 on the same cycle as a pop of pc 0.
  - Required: pop counted; the entry for pc 4 already in the buffer is flushed; out_valid=0 for one cycle; next head pc=4 with instr 0x00100113.
- Redirect to 0x6 while in RUN.
  - Required: fault=1 next cycle, out_valid=0, no further fetches.
  - Then redirect to 0x0: fault=0 and fetching resumes from 0.
- Assert reset_n=0 asynchronously mid-cycle with 2 entries buffered.
  - Required: out_valid, halted, fault and fetch_count go to 0 immediately; imem_addr=RESET_PC.
- Set the pc to 32'hFFFF_FFFC with a nonzero word at that address.
  - Required: push with out_pc_plus4=0; pc wraps to 0.
